// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO read-side packer.
package fifo_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_PACK       = 4;
    localparam int unsigned DEF_CNT_WIDTH  = 16;
    localparam int unsigned KEEP_MAX_W     = 32;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        EMIT  = 2'd2
    } pack_state_e;

    // Mask with the low n bits set (saturates at KEEP_MAX_W lanes).
    function automatic logic [KEEP_MAX_W-1:0] keep_mask(input int unsigned n);
        if (n >= KEEP_MAX_W) begin
            return '1;
        end
        return (KEEP_MAX_W'(1) << n) - KEEP_MAX_W'(1);
    endfunction

endpackage

// File: rtl/fifo_rd_packer_out_reg.sv
// Output holding register: valid/ready stage with a load port and a free indication.
module pack_out_reg #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned LANES  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [WORD_W-1:0] load_data,
    input  logic [LANES-1:0]  load_keep,
    input  logic              ready,
    output logic              valid,
    output logic [WORD_W-1:0] data,
    output logic [LANES-1:0]  keep,
    output logic              free_c
);

    assign free_c = ~valid | ready;

    // Data and keep only change on a load, so they stay stable while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            keep  <= '0;
        end else if (load_en) begin
            valid <= 1'b1;
            data  <= load_data;
            keep  <= load_keep;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_rd_packer.sv
// Pops FIFO entries, packs PACK of them into one output word; flush emits a partial word.
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned PACK       = DEF_PACK,
    parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                       io_clk,
    input  logic                       io_nrst,
    input  logic                       io_fifo_empty,
    input  logic [DATA_WIDTH-1:0]      io_fifo_rdata,
    output logic                       io_fifo_rd_en,
    input  logic                       io_flush,
    output logic                       io_out_valid,
    input  logic                       io_out_ready,
    output logic [DATA_WIDTH*PACK-1:0] io_out_data,
    output logic [PACK-1:0]            io_out_keep,
    output logic                       io_busy,
    output logic [CNT_WIDTH-1:0]       io_word_cnt
);

    localparam int unsigned WORD_W = DATA_WIDTH * PACK;
    localparam int unsigned CW     = $clog2(PACK + 1);

    pack_state_e       state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic              inflight;
    logic [WORD_W-1:0] acc, acc_nxt;

    logic              out_free_c;
    logic              load_en_c;
    logic [WORD_W-1:0] load_data_c;
    logic [PACK-1:0]   load_keep_c;
    logic [PACK-1:0]   part_keep_c;
    logic [WORD_W-1:0] part_mask_c;
    logic [CW:0]       occ_c;
    logic              rd_en_c;

    pack_out_reg #(
        .WORD_W (WORD_W),
        .LANES  (PACK)
    ) u_out (
        .clk       (io_clk),
        .rst_n     (io_nrst),
        .load_en   (load_en_c),
        .load_data (load_data_c),
        .load_keep (load_keep_c),
        .ready     (io_out_ready),
        .valid     (io_out_valid),
        .data      (io_out_data),
        .keep      (io_out_keep),
        .free_c    (out_free_c)
    );

    // Accepted pops plus the entry on the way must always fit in the accumulator.
    always_comb begin
        occ_c   = {1'b0, cnt} + {{CW{1'b0}}, inflight};
        rd_en_c = ~io_fifo_empty & (state == RUN) & ~io_flush &
                  ((occ_c < (CW+1)'(PACK)) |
                   ((occ_c == (CW+1)'(PACK)) & inflight & out_free_c));
    end

    assign io_fifo_rd_en = io_nrst & rd_en_c;
    assign io_busy       = (state != RUN);

    always_comb begin
        part_keep_c = PACK'(keep_mask(32'(cnt)));
        part_mask_c = '0;
        for (int unsigned i = 0; i < PACK; i++) begin
            part_mask_c[i*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{part_keep_c[i]}};
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        acc_nxt     = acc;
        load_en_c   = 1'b0;
        load_data_c = acc;
        load_keep_c = '1;

        if (cnt == CW'(PACK)) begin
            if (out_free_c) begin
                load_en_c = 1'b1;
                cnt_nxt   = '0;
            end
        end else if (inflight) begin
            for (int unsigned i = 0; i < PACK; i++) begin
                if (cnt == CW'(i)) begin
                    acc_nxt[i*DATA_WIDTH +: DATA_WIDTH] = io_fifo_rdata;
                end
            end
            if (cnt == CW'(PACK - 1)) begin
                if (out_free_c) begin
                    load_en_c   = 1'b1;
                    load_data_c = acc_nxt;
                    cnt_nxt     = '0;
                end else begin
                    cnt_nxt = CW'(PACK);
                end
            end else begin
                cnt_nxt = cnt + CW'(1);
            end
        end

        case (state)
            RUN: begin
                if (io_flush) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // A held full word (cnt==PACK) drains through the normal path first.
                if (!inflight) begin
                    if (cnt == '0) begin
                        state_nxt = RUN;
                    end else if (cnt != CW'(PACK)) begin
                        state_nxt = EMIT;
                    end
                end
            end
            EMIT: begin
                if (out_free_c) begin
                    load_en_c   = 1'b1;
                    load_data_c = acc & part_mask_c;
                    load_keep_c = part_keep_c;
                    cnt_nxt     = '0;
                    state_nxt   = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge io_clk or negedge io_nrst) begin
        if (!io_nrst) begin
            state       <= RUN;
            cnt         <= '0;
            inflight    <= 1'b0;
            acc         <= '0;
            io_word_cnt <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            inflight <= rd_en_c;
            acc      <= acc_nxt;
            if (io_out_valid && io_out_ready) begin
                io_word_cnt <= io_word_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Self-checking bench for fifo_rd_packer: FIFO model, word-stream reference model, directed tables.
module tb_fifo_rd_packer;

    localparam int unsigned DW = 8;
    localparam int unsigned PK = 4;
    localparam int unsigned CW = 16;

    logic            clk;
    logic            rst_n;
    logic            fifo_empty;
    logic [DW-1:0]   fifo_rdata;
    logic            fifo_rd_en;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [DW*PK-1:0] out_data;
    logic [PK-1:0]   out_keep;
    logic            busy;
    logic [CW-1:0]   word_cnt;

    fifo_rd_packer #(.DATA_WIDTH(DW), .PACK(PK), .CNT_WIDTH(CW)) dut (
        .io_clk        (clk),
        .io_nrst       (rst_n),
        .io_fifo_empty (fifo_empty),
        .io_fifo_rdata (fifo_rdata),
        .io_fifo_rd_en (fifo_rd_en),
        .io_flush      (flush),
        .io_out_valid  (out_valid),
        .io_out_ready  (out_ready),
        .io_out_data   (out_data),
        .io_out_keep   (out_keep),
        .io_busy       (busy),
        .io_word_cnt   (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned nent;
        logic [7:0]  first;
        logic [7:0]  step;
        bit          do_flush;
        logic [31:0] word;
        logic [3:0]  keep;
    } vec_t;

    int          checks;
    int          errors;
    logic [7:0]  fq[$];
    logic [7:0]  pend[$];
    logic [35:0] exp_q[$];
    logic [35:0] got_q[$];
    logic        hold_empty;
    int          hs_count;
    int          pop_count;
    int          rd_run;
    int          rd_run_max;
    int          busy_cycles;
    logic        prev_stall;
    logic [35:0] prev_word;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive_empty();
        fifo_empty = (fq.size() == 0) | hold_empty;
    endtask

    task automatic push(input logic [7:0] v);
        fq.push_back(v);
        drive_empty();
    endtask

    // Reference model: every popped entry joins the pending group; a full group or an accepted flush forms a word.
    task automatic model_emit();
        logic [35:0] w;
        w = '0;
        for (int i = 0; i < pend.size(); i++) begin
            w[i*8 +: 8] = pend[i];
            w[32 + i]   = 1'b1;
        end
        if (pend.size() > 0) exp_q.push_back(w);
        pend.delete();
    endtask

    task automatic tick();
        logic [7:0] pv;
        logic       pop;
        pv = 8'($urandom);
        @(negedge clk);
        check("no_pop_when_empty", 64'(fifo_rd_en & fifo_empty), 64'(0));
        check("word_cnt", 64'(word_cnt), 64'(16'(hs_count)));
        if (prev_stall) begin
            check("hold_valid", 64'(out_valid), 64'(1));
            check("hold_data", 64'({out_keep, out_data}), 64'(prev_word));
        end
        prev_stall = out_valid & ~out_ready;
        prev_word  = {out_keep, out_data};
        if (busy) busy_cycles++;
        if (flush) model_emit();
        pop = fifo_rd_en;
        if (pop) begin
            if (fq.size() > 0) pv = fq.pop_front();
            pend.push_back(pv);
            pop_count++;
            rd_run++;
            if (rd_run > rd_run_max) rd_run_max = rd_run;
            if (pend.size() == PK) model_emit();
        end else begin
            rd_run = 0;
        end
        if (out_valid && out_ready) begin
            got_q.push_back({out_keep, out_data});
            if (exp_q.size() == 0) begin
                check("spurious_word", 64'({out_keep, out_data}), 64'(0));
            end else begin
                check("word", 64'({out_keep, out_data}), 64'(exp_q.pop_front()));
            end
            hs_count++;
        end
        @(posedge clk);
        #1;
        fifo_rdata = pop ? pv : 8'($urandom);
        flush      = 1'b0;
        drive_empty();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_en"}, 64'(fifo_rd_en), 64'(0));
        check({tag, "_valid"}, 64'(out_valid), 64'(0));
        check({tag, "_data"},  64'(out_data), 64'(0));
        check({tag, "_keep"},  64'(out_keep), 64'(0));
        check({tag, "_busy"},  64'(busy), 64'(0));
        check({tag, "_wcnt"},  64'(word_cnt), 64'(0));
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        fifo_rdata = 8'($urandom);
        #1;
        check_reset_outputs("rst_mid");
        repeat (2) @(posedge clk);
        #1;
        pend.delete();
        exp_q.delete();
        hs_count   = 0;
        prev_stall = 1'b0;
        rd_run     = 0;
        rst_n      = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[6];
        int   g0, p0, h0, b0, since;

        tbl[0] = '{4, 8'h11, 8'h11, 1'b0, 32'h44332211, 4'hF};
        tbl[1] = '{4, 8'h55, 8'h11, 1'b0, 32'h88776655, 4'hF};
        tbl[2] = '{3, 8'hA1, 8'h01, 1'b1, 32'h00A3A2A1, 4'h7};
        tbl[3] = '{1, 8'h5A, 8'h01, 1'b1, 32'h0000005A, 4'h1};
        tbl[4] = '{2, 8'hC0, 8'h01, 1'b1, 32'h0000C1C0, 4'h3};
        tbl[5] = '{4, 8'hF0, 8'h01, 1'b1, 32'hF3F2F1F0, 4'hF};

        checks = 0; errors = 0; hs_count = 0; pop_count = 0;
        rd_run = 0; rd_run_max = 0; busy_cycles = 0; prev_stall = 1'b0; prev_word = '0;
        hold_empty = 1'b0;
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0; fifo_rdata = '0;
        fifo_empty = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        drive_empty();
        rst_n = 1'b1;

        // Directed table: entries in, one word out (full or flushed partial).
        for (int t = 0; t < 6; t++) begin
            out_ready = 1'b1;
            g0 = got_q.size();
            for (int k = 0; k < int'(tbl[t].nent); k++) push(8'(tbl[t].first + 8'(tbl[t].step * 8'(k))));
            repeat (8) tick();
            if (tbl[t].do_flush) begin
                flush = 1'b1;
                tick();
            end
            for (int w = 0; w < 12 && got_q.size() == g0; w++) tick();
            check($sformatf("tbl%0d_got", t), 64'(got_q.size() > g0), 64'(1));
            check($sformatf("tbl%0d_word", t), 64'(got_q.size() > g0 ? got_q[g0] : 36'd0),
                  64'({tbl[t].keep, tbl[t].word}));
        end

        // Streaming at full rate.
        repeat (3) tick();
        out_ready = 1'b1; rd_run_max = 0; p0 = pop_count; h0 = hs_count; g0 = got_q.size();
        for (int k = 1; k <= 8; k++) push(8'(8'h11 * 8'(k)));
        repeat (14) tick();
        check("stream_rd_run", 64'(rd_run_max), 64'(8));
        check("stream_pops", 64'(pop_count - p0), 64'(8));
        check("stream_words", 64'(hs_count - h0), 64'(2));
        check("stream_wcnt", 64'(word_cnt), 64'(16'(h0 + 2)));
        check("stream_w0", 64'(got_q.size() > g0 ? got_q[g0] : 36'd0), 64'({4'hF, 32'h44332211}));
        check("stream_w1", 64'(got_q.size() > g0 + 1 ? got_q[g0 + 1] : 36'd0), 64'({4'hF, 32'h88776655}));

        // Backpressure: pops stop once the accumulator holds the second word.
        out_ready = 1'b0; p0 = pop_count; h0 = hs_count; g0 = got_q.size();
        for (int k = 1; k <= 8; k++) push(8'(8'h11 * 8'(k)));
        repeat (10) tick();
        check("bp_pops", 64'(pop_count - p0), 64'(8));
        check("bp_valid", 64'(out_valid), 64'(1));
        check("bp_data", 64'({out_keep, out_data}), 64'({4'hF, 32'h44332211}));
        repeat (3) tick();
        check("bp_pops_stopped", 64'(pop_count - p0), 64'(8));
        out_ready = 1'b1;
        repeat (6) tick();
        check("bp_words", 64'(hs_count - h0), 64'(2));
        check("bp_w1", 64'(got_q.size() > g0 + 1 ? got_q[g0 + 1] : 36'd0), 64'({4'hF, 32'h88776655}));

        // Partial flush with busy observed until the word appears.
        g0 = got_q.size();
        push(8'hA1); push(8'hA2); push(8'hA3);
        repeat (6) tick();
        b0 = busy_cycles;
        flush = 1'b1;
        tick();
        for (int w = 0; w < 12 && got_q.size() == g0; w++) tick();
        check("pflush_busy_seen", 64'(busy_cycles > b0), 64'(1));
        check("pflush_word", 64'(got_q.size() > g0 ? got_q[g0] : 36'd0), 64'({4'h7, 32'h00A3A2A1}));
        repeat (2) tick();
        check("pflush_back_run", 64'(busy), 64'(0));

        // Flush with nothing buffered.
        repeat (3) tick();
        b0 = busy_cycles; h0 = hs_count;
        flush = 1'b1;
        repeat (6) tick();
        check("eflush_busy_cycles", 64'(busy_cycles - b0), 64'(1));
        check("eflush_no_word", 64'(hs_count - h0), 64'(0));

        // Reset after two entries landed; the next four form a fresh word.
        for (int k = 0; k < 8; k++) push(8'(8'hB0 + 8'(k)));
        repeat (3) tick();
        do_reset();
        g0 = got_q.size();
        repeat (10) tick();
        check("rst_word", 64'(got_q.size() > g0 ? got_q[g0] : 36'd0), 64'({4'hF, 32'hB6B5B4B3}));
        flush = 1'b1;
        repeat (8) tick();

        // Random data, FIFO empty on alternate cycles, random backpressure and occasional flushes.
        since = 100;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 1) == 1) push(8'($urandom));
            hold_empty = (i % 2) == 1;
            drive_empty();
            if (since >= 20 && $urandom_range(0, 15) == 0) begin
                flush = 1'b1;
                since = 0;
            end
            out_ready = (since < 6) ? 1'b1 : ($urandom_range(0, 3) != 0);
            since++;
            tick();
        end
        hold_empty = 1'b0; out_ready = 1'b1;
        drive_empty();
        for (int w = 0; w < 200 && fq.size() > 0; w++) tick();
        check("rand_fifo_drained", 64'(fq.size()), 64'(0));
        repeat (4) tick();
        flush = 1'b1;
        repeat (12) tick();
        check("rand_all_words_out", 64'(exp_q.size()), 64'(0));
        check("rand_final_idle", 64'({busy, out_valid}), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
